// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider bank.
// Contents:
//   CNT_W_DEFAULT  default divisor/counter width
//   MIN_DIV        smallest legal divisor; requests of 0 or 1 are raised to this value
//   ch_state_e     per-channel run/stop state
//   clamp_div()    raise a requested divisor to MIN_DIV
//   high_len()     number of high cycles in one period, (D+1)>>1
package clk_div_pkg;

  localparam int CNT_W_DEFAULT = 12;
  localparam int MIN_DIV       = 2;

  typedef enum logic [1:0] {
    CH_IDLE     = 2'd0,
    CH_RUN      = 2'd1,
    CH_STOPPING = 2'd2
  } ch_state_e;

  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'(MIN_DIV)) ? 32'(MIN_DIV) : d;
  endfunction

  // Odd divisors give the extra cycle to the high phase.
  function automatic logic [31:0] high_len(input logic [31:0] d);
    return (d + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clk_divider_bank_if.sv
// Bus bundle between the divider bank and its user.
// Ports (seen from the slave / divider bank side):
//   en[NUM_CH]        in   per-channel run request (level)
//   sync_start        in   one-cycle pulse restarting every enabled channel in phase
//   cfg_wr            in   one-cycle divisor write strobe
//   cfg_ch[CH_W]      in   target channel of cfg_wr
//   cfg_div[CNT_W]    in   requested divisor
//   clk_out[NUM_CH]   out  divided clock levels
//   rise_stb[NUM_CH]  out  strobe on the first high cycle of each period
//   fall_stb[NUM_CH]  out  strobe on the first low cycle of each period
//   running[NUM_CH]   out  channel is counting
//   cfg_busy[NUM_CH]  out  divisor write waiting to be applied
interface clk_divider_bank_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 12,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);

  logic [NUM_CH-1:0] en;
  logic              sync_start;
  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] rise_stb;
  logic [NUM_CH-1:0] fall_stb;
  logic [NUM_CH-1:0] running;
  logic [NUM_CH-1:0] cfg_busy;

  modport master (
    output en, sync_start, cfg_wr, cfg_ch, cfg_div,
    input  clk_out, rise_stb, fall_stb, running, cfg_busy
  );

  modport slave (
    input  en, sync_start, cfg_wr, cfg_ch, cfg_div,
    output clk_out, rise_stb, fall_stb, running, cfg_busy
  );

endinterface

// File: rtl/clk_div_channel.sv
// One programmable divider channel: period counter, active and pending
// divisor, and the run/stop state machine.
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   en          run request (level)
//   sync_start  restart at cnt=0 if en is high
//   cfg_wr      divisor write strobe for this channel
//   cfg_div     requested divisor (0/1 stored as 2)
//   clk_out     divided clock level (registered)
//   rise_stb    first high cycle of a period
//   fall_stb    first low cycle of a period
//   running     channel is counting
//   cfg_busy    divisor write pending
//
// state        | meaning
// CH_IDLE      | stopped, cnt held at 0, outputs low, pending divisor applied every edge
// CH_RUN       | counting 0..D-1 and wrapping
// CH_STOPPING  | en dropped; finish the current period, then go idle at the wrap
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_start,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             clk_out,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             running,
  output logic             cfg_busy
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_out_q, clk_out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  logic             wrap;
  logic             restart;
  logic             apply;
  logic             run_nxt;
  logic [CNT_W-1:0] high_nxt;

  assign wrap    = (state_q != CH_IDLE) && (cnt_q == div_act_q - ONE);
  assign restart = sync_start && en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CH_IDLE;
      cnt_q      <= '0;
      div_act_q  <= RST_DIV;
      pend_div_q <= RST_DIV;
      pend_vld_q <= 1'b0;
      clk_out_q  <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      pend_div_q <= pend_div_d;
      pend_vld_q <= pend_vld_d;
      clk_out_q  <= clk_out_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end

  // Stopping is decided at the wrap edge: en low there ends the channel,
  // en back high before then resumes counting without a break.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CH_IDLE:     if (en) state_d = CH_RUN;
      CH_RUN:      if (!en) state_d = wrap ? CH_IDLE : CH_STOPPING;
      CH_STOPPING: begin
        if (en)        state_d = CH_RUN;
        else if (wrap) state_d = CH_IDLE;
      end
      default:     state_d = CH_IDLE;
    endcase
    if (restart) state_d = CH_RUN;
  end

  // Datapath and registered outputs, all derived from the next counter value
  // so the outputs line up with cnt in the same cycle.
  always_comb begin
    // A divisor only takes effect on a period boundary (or while idle), so
    // the output never sees a truncated or stretched phase.
    apply      = pend_vld_q && ((state_q == CH_IDLE) || wrap || restart);
    div_act_d  = apply ? pend_div_q : div_act_q;
    pend_div_d = pend_div_q;
    pend_vld_d = pend_vld_q && !apply;
    // A write landing on the apply edge still commits the old value and
    // leaves the new one pending.
    if (cfg_wr) begin
      pend_div_d = CNT_W'(clamp_div(32'(cfg_div)));
      pend_vld_d = 1'b1;
    end

    run_nxt = (state_d != CH_IDLE);
    cnt_d   = '0;
    if (run_nxt && !restart && (state_q != CH_IDLE) && !wrap) begin
      cnt_d = cnt_q + ONE;
    end

    high_nxt  = CNT_W'(high_len(32'(div_act_d)));
    clk_out_d = run_nxt && (cnt_d < high_nxt);
    rise_d    = run_nxt && (cnt_d == '0);
    fall_d    = run_nxt && (cnt_d == high_nxt);
  end

  assign clk_out  = clk_out_q;
  assign rise_stb = rise_q;
  assign fall_stb = fall_q;
  assign running  = (state_q != CH_IDLE);
  assign cfg_busy = pend_vld_q;

endmodule

// File: rtl/clk_divider_bank.sv
// Bank of NUM_CH independent programmable clock dividers on one clock.
// Ports:
//   clk    system clock, all logic on posedge
//   rst    synchronous active-high reset
//   bus    clk_divider_bank_if slave: run requests, sync_start, divisor
//          writes in; divided levels, strobes, running and cfg_busy out
module clk_divider_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  clk_divider_bank_if.slave  bus
);

  logic [NUM_CH-1:0] wr_stb;
  logic [NUM_CH-1:0] clk_out_v;
  logic [NUM_CH-1:0] rise_v;
  logic [NUM_CH-1:0] fall_v;
  logic [NUM_CH-1:0] running_v;
  logic [NUM_CH-1:0] busy_v;

  // Out-of-range channel numbers match no strobe and are dropped.
  always_comb begin
    wr_stb = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.cfg_wr && (32'(bus.cfg_ch) == i)) wr_stb[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en         (bus.en[g]),
      .sync_start (bus.sync_start),
      .cfg_wr     (wr_stb[g]),
      .cfg_div    (bus.cfg_div),
      .clk_out    (clk_out_v[g]),
      .rise_stb   (rise_v[g]),
      .fall_stb   (fall_v[g]),
      .running    (running_v[g]),
      .cfg_busy   (busy_v[g])
    );
  end

  assign bus.clk_out  = clk_out_v;
  assign bus.rise_stb = rise_v;
  assign bus.fall_stb = fall_v;
  assign bus.running  = running_v;
  assign bus.cfg_busy = busy_v;

endmodule
